rcv_block_param: RTL and testbench
==================================

# rcv_block_param

Parametrised UART receiver, successor to the fixed 8N1 receive block. It adds configurable data width, bit period, optional even/odd parity, false-start rejection and a multi-entry receive FIFO in place of the single-entry data buffer. It sits between the serial pin and the bus-side register interface. Framing, parity and overrun status are reported as sticky flags.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..8
- CLKS_PER_BIT, 10: clk cycles per serial bit, legal even values >= 4
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd
- FIFO_DEPTH, 4: receive FIFO entries, power of 2, >= 2
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  synchronous active-low reset
- serial_in  input  1  asynchronous serial line, idle high
- data_read  input  1  pops the FIFO head; ignored when data_ready = 0
- rx_data  output  DATA_BITS  FIFO head (first-word fall-through); 0 when empty
- data_ready  output  1  FIFO not empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
- framing_error  output  1  sticky: last frame had stop bit = 0
- parity_error  output  1  sticky: last frame had parity mismatch
- overrun_error  output  1  sticky: a good frame was dropped because the FIFO was full

## Operation
- serial_in passes through a 2-flop synchronizer (reset value 1). All sampling uses the synchronized value.
- FSM states and transitions:
  - IDLE: a falling edge (previous synchronized value = 1, current = 0) goes to START and clears the bit-period counter.
  - START: at count CLKS_PER_BIT/2-1, sample. If the line is 0, clear framing_error/parity_error, zero the counter and go to DATA. If it is 1, the start is false: return to IDLE with no flag change.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples. Then go to PARITY if PARITY_MODE != 0, otherwise STOP.
  - PARITY: one sample, compared with the XOR of the data bits (even mode) or its inverse (odd mode).
  - STOP: one sample, then to IDLE on the same edge.
- Frame result, evaluated on the stop sample:
  - Stop = 0: set framing_error and discard the frame, even if parity was also bad.
  - Else parity bad: set parity_error and discard.
  - Else good: push into the FIFO. If the FIFO is full and there is no pop this cycle, drop the frame and set overrun_error.
- Simultaneous push and pop on a full FIFO: both happen, count unchanged, no overrun.
- overrun_error clears on the first accepted data_read pop after it was set.
- Error flags never clear on their own in any other way.
- Reset values: FSM IDLE, FIFO empty, fifo_count 0, data_ready 0, rx_data 0, all error flags 0.
- A reset mid-frame abandons the frame; the line must then be seen high before a new start is detected.

## Timing
- Let T0 be the edge on which the falling edge is detected (2 cycles after the serial_in transition).
- Start-bit verify sample is at T0 + CLKS_PER_BIT/2.
- Data sample k (0-based) is at T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Stop sample is at T0 + CLKS_PER_BIT/2 + (DATA_BITS + P + 1)·CLKS_PER_BIT, where P = 1 if parity is enabled.
- The push is registered on the stop-sample edge. data_ready, rx_data and the flags update 1 cycle after the stop sample.
- Pop takes effect on the edge where data_read = 1. The next entry (or empty) is visible the following cycle.
- A back-to-back frame whose start edge arrives half a bit after the stop sample is received without loss.

## Structure
- Package rcv_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - the PARITY_NONE/EVEN/ODD constants
- Sub-module rcv_fifo: synchronous FIFO parametrised by width and depth. It provides push, pop, head, count and full/empty, with pointer wrap on power-of-2 depth.
- The top level contains the synchronizer, FSM, bit-period counter, bit counter, shift register and status flags.

## Test plan
- Defaults, send 0xA5 8N1: rx_data = 0xA5, data_ready = 1 one cycle after the stop sample, fifo_count = 1, all flags 0.
- PARITY_MODE = 1, send 0x03 with parity bit 1: frame discarded, parity_error = 1, data_ready stays 0. Then a correct 0x07 frame: pushed, parity_error clears at its start verify.
- Stop bit driven 0 on 0x55: framing_error = 1, nothing pushed. A 1-cycle low glitch at idle: no START, no flag change.
- Send 5 frames 0x01..0x05 without reads (depth 4): FIFO holds 0x01..0x04, overrun_error = 1. One pop: rx_data = 0x02, overrun_error = 0.
- FIFO full with a pop on the exact stop-sample edge of a 5th frame: count stays 4, no overrun, order preserved.
- DATA_BITS = 7, CLKS_PER_BIT = 16, assert n_rst = 0 mid-data-bit: all outputs return to reset values next edge. The next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/rcv_pkg.sv
// Shared types and constants for the parametrised UART receive block.
package rcv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rcv_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

endpackage

// File: rtl/rcv_fifo.sv
// Synchronous first-word fall-through FIFO; head reads as zero while empty.
module rcv_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AddrW + 1)'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AddrW'(1);
      if (do_pop)  rptr_q <= rptr_q + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AddrW + 1)'(1);
        2'b01:   count_q <= count_q - (AddrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rcv_block_param.sv
// Parametrised UART receiver: synchronizer, frame FSM, sticky status flags and a receive FIFO.
module rcv_block_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          serial_in,
  input  logic                          data_read,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_error,
  output logic                          parity_error,
  output logic                          overrun_error
);

  import rcv_pkg::*;

  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LastBit = 4'(DATA_BITS - 1);
  localparam logic ParOdd = (PARITY_MODE == PARITY_ODD);

  rcv_state_e           state_q, state_d;
  logic [1:0]           sync_q, valid_q;
  logic                 prev_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 framing_q, framing_d, parity_q, parity_d, overrun_q, overrun_d;
  logic                 line_s, fall, push, pop_acc, fifo_full, fifo_empty;

  assign line_s  = sync_q[1];
  // prev_q only holds a 1 once the line has really been seen high since reset.
  assign fall    = prev_q & ~line_s;
  assign pop_acc = data_read & ~fifo_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    framing_d = framing_q;
    parity_d  = parity_q;
    overrun_d = overrun_q;
    push      = 1'b0;
    if (pop_acc) overrun_d = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d = '0;
          if (!line_s) begin
            framing_d = 1'b0;
            parity_d  = 1'b0;
            par_bad_d = 1'b0;
            bit_d     = '0;
            state_d   = StData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {line_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == LastBit) begin
            if (PARITY_MODE != PARITY_NONE) state_d = StParity;
            else                            state_d = StStop;
          end
        end
      end
      StParity: begin
        if (cnt_q == FullM1) begin
          cnt_d     = '0;
          par_bad_d = line_s ^ (^shift_q) ^ ParOdd;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (!line_s)                    framing_d = 1'b1;
          else if (par_bad_q)             parity_d  = 1'b1;
          else if (fifo_full && !pop_acc) overrun_d = 1'b1;
          else                            push      = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      sync_q    <= 2'b11;
      valid_q   <= 2'b00;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      framing_q <= 1'b0;
      parity_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], serial_in};
      valid_q   <= {valid_q[0], 1'b1};
      prev_q    <= line_s & valid_q[1];
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      framing_q <= framing_d;
      parity_q  <= parity_d;
      overrun_q <= overrun_d;
    end
  end

  rcv_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (n_rst),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop_acc),
    .head_o  (rx_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign data_ready    = ~fifo_empty;
  assign framing_error = framing_q;
  assign parity_error  = parity_q;
  assign overrun_error = overrun_q;

endmodule

// File: tb/tb_rcv_block_param.sv
// Directed bench for rcv_block_param: default 8N1, even parity, and 7-bit/16-clock instances.
module tb_rcv_block_param;

  logic clk;
  logic n_rst, n_rst_d7;
  logic ser_def, ser_par, ser_d7;
  logic rd_def, rd_par, rd_d7;
  logic [7:0] rx_def, rx_par;
  logic [6:0] rx_d7;
  logic rdy_def, rdy_par, rdy_d7;
  logic [2:0] cnt_def, cnt_par, cnt_d7;
  logic fe_def, pe_def, oe_def, fe_par, pe_par, oe_par, fe_d7, pe_d7, oe_d7;

  int checks = 0;
  int errors = 0;

  rcv_block_param u_def (
    .clk (clk), .n_rst (n_rst), .serial_in (ser_def), .data_read (rd_def),
    .rx_data (rx_def), .data_ready (rdy_def), .fifo_count (cnt_def),
    .framing_error (fe_def), .parity_error (pe_def), .overrun_error (oe_def)
  );

  rcv_block_param #(.PARITY_MODE (1)) u_par (
    .clk (clk), .n_rst (n_rst), .serial_in (ser_par), .data_read (rd_par),
    .rx_data (rx_par), .data_ready (rdy_par), .fifo_count (cnt_par),
    .framing_error (fe_par), .parity_error (pe_par), .overrun_error (oe_par)
  );

  rcv_block_param #(.DATA_BITS (7), .CLKS_PER_BIT (16)) u_d7 (
    .clk (clk), .n_rst (n_rst_d7), .serial_in (ser_d7), .data_read (rd_d7),
    .rx_data (rx_d7), .data_ready (rdy_d7), .fifo_count (cnt_d7),
    .framing_error (fe_d7), .parity_error (pe_d7), .overrun_error (oe_d7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         which;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic       exp_ready;
    logic [7:0] exp_data;
    int         exp_count;
    logic       exp_fe;
    logic       exp_pe;
    logic       exp_oe;
    int         pops;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0:       ser_def = v;
      1:       ser_par = v;
      default: ser_d7  = v;
    endcase
  endtask

  function automatic int nbits_of(input int which);
    return (which == 2) ? 7 : 8;
  endfunction

  function automatic int cpb_of(input int which);
    return (which == 2) ? 16 : 10;
  endfunction

  task automatic pop(input int which);
    case (which)
      0:       rd_def = 1'b1;
      1:       rd_par = 1'b1;
      default: rd_d7  = 1'b1;
    endcase
    wait_cycles(1);
    rd_def = 1'b0;
    rd_par = 1'b0;
    rd_d7  = 1'b0;
  endtask

  // Data bits, optional parity and stop; the stop level is held stop_hold cycles.
  task automatic send_tail(input int which, input logic [7:0] data, input logic par_bit,
                           input logic stop_bit, input int stop_hold);
    for (int i = 0; i < nbits_of(which); i++) begin
      set_line(which, data[i]);
      wait_cycles(cpb_of(which));
    end
    if (which == 1) begin
      set_line(which, par_bit);
      wait_cycles(cpb_of(which));
    end
    set_line(which, stop_bit);
    wait_cycles(stop_hold);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input logic par_bit,
                            input logic stop_bit, input int stop_hold);
    set_line(which, 1'b0);
    wait_cycles(cpb_of(which));
    send_tail(which, data, par_bit, stop_bit, stop_hold);
  endtask

  task automatic send_idle(input int which, input logic [7:0] data, input logic par_bit,
                           input logic stop_bit);
    send_frame(which, data, par_bit, stop_bit, cpb_of(which));
    set_line(which, 1'b1);
    wait_cycles(cpb_of(which));
  endtask

  task automatic check_all(input int which, input string tag, input logic ready,
                           input logic [7:0] data, input int count, input logic fe,
                           input logic pe, input logic oe);
    logic r, f, p, o;
    logic [7:0] d;
    logic [2:0] c;
    case (which)
      0: begin r = rdy_def; d = rx_def; c = cnt_def; f = fe_def; p = pe_def; o = oe_def; end
      1: begin r = rdy_par; d = rx_par; c = cnt_par; f = fe_par; p = pe_par; o = oe_par; end
      default: begin
        r = rdy_d7; d = {1'b0, rx_d7}; c = cnt_d7; f = fe_d7; p = pe_d7; o = oe_d7;
      end
    endcase
    check({tag, " data_ready"}, 32'(r), 32'(ready));
    check({tag, " rx_data"}, 32'(d), 32'(data));
    check({tag, " fifo_count"}, 32'(c), 32'(count));
    check({tag, " framing_error"}, 32'(f), 32'(fe));
    check({tag, " parity_error"}, 32'(p), 32'(pe));
    check({tag, " overrun_error"}, 32'(o), 32'(oe));
  endtask

  initial begin
    vecs[0] = '{0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1, 1'b0, 1'b0, 1'b0, 1};
    vecs[2] = '{1, 8'h03, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 0};
    vecs[3] = '{1, 8'h0F, 1'b0, 1'b1, 1'b1, 8'h0F, 1, 1'b0, 1'b0, 1'b0, 1};
    vecs[4] = '{1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{1, 8'h03, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 0};
    vecs[6] = '{2, 8'h2A, 1'b0, 1'b1, 1'b1, 8'h2A, 1, 1'b0, 1'b0, 1'b0, 0};
    vecs[7] = '{2, 8'h11, 1'b0, 1'b0, 1'b1, 8'h2A, 1, 1'b1, 1'b0, 1'b0, 0};

    n_rst = 1'b0; n_rst_d7 = 1'b0;
    ser_def = 1'b1; ser_par = 1'b1; ser_d7 = 1'b1;
    rd_def = 1'b0; rd_par = 1'b0; rd_d7 = 1'b0;
    wait_cycles(3);
    n_rst = 1'b1; n_rst_d7 = 1'b1;
    wait_cycles(5);
    check_all(0, "reset", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    check("reset d7 fifo_count", 32'(cnt_d7), 32'd0);

    // 0xA5 8N1: stop sample lands 98 edges after the start transition.
    send_frame(0, 8'hA5, 1'b0, 1'b1, 7);
    check("a5 early data_ready", 32'(rdy_def), 32'd0);
    wait_cycles(1);
    check_all(0, "a5", 1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    pop(0);
    check("a5 popped data_ready", 32'(rdy_def), 32'd0);

    for (int i = 0; i < 8; i++) begin
      send_idle(vecs[i].which, vecs[i].data, vecs[i].par_bit, vecs[i].stop_bit);
      check_all(vecs[i].which, $sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_data,
                vecs[i].exp_count, vecs[i].exp_fe, vecs[i].exp_pe, vecs[i].exp_oe);
      for (int p = 0; p < vecs[i].pops; p++) pop(vecs[i].which);
    end

    // Even-parity 0x07: parity_error drops exactly at the start-bit verify sample.
    set_line(1, 1'b0);
    wait_cycles(7);
    check("par pe before verify", 32'(pe_par), 32'd1);
    wait_cycles(1);
    check("par pe after verify", 32'(pe_par), 32'd0);
    wait_cycles(2);
    send_tail(1, 8'h07, 1'b1, 1'b1, 10);
    wait_cycles(10);
    check_all(1, "par07", 1'b1, 8'h07, 1, 1'b0, 1'b0, 1'b0);

    // Framing error, then a 1-cycle glitch must leave everything untouched.
    send_idle(0, 8'h55, 1'b0, 1'b0);
    set_line(0, 1'b0);
    wait_cycles(1);
    set_line(0, 1'b1);
    wait_cycles(30);
    check_all(0, "glitch", 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0);
    send_idle(0, 8'h5A, 1'b0, 1'b1);
    check_all(0, "after glitch", 1'b1, 8'h5A, 1, 1'b0, 1'b0, 1'b0);
    pop(0);

    // Overrun: fifth frame dropped, first pop clears the flag.
    for (int i = 1; i <= 5; i++) send_idle(0, 8'(i), 1'b0, 1'b1);
    check_all(0, "overrun", 1'b1, 8'h01, 4, 1'b0, 1'b0, 1'b1);
    pop(0);
    check_all(0, "overrun pop", 1'b1, 8'h02, 3, 1'b0, 1'b0, 1'b0);
    pop(0); pop(0);
    check("overrun drain head", 32'(rx_def), 32'h04);
    pop(0);
    check_all(0, "drained", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    pop(0);
    check("empty pop ignored", 32'(cnt_def), 32'd0);

    // Full FIFO with a pop on the exact stop-sample edge of the fifth frame.
    for (int i = 0; i < 4; i++) send_idle(0, 8'h11 + 8'(i), 1'b0, 1'b1);
    send_frame(0, 8'h15, 1'b0, 1'b1, 7);
    rd_def = 1'b1;
    wait_cycles(1);
    rd_def = 1'b0;
    check_all(0, "full pop", 1'b1, 8'h12, 4, 1'b0, 1'b0, 1'b0);
    wait_cycles(12);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full order %0d", i), 32'(rx_def), 32'h12 + 32'(i));
      pop(0);
    end
    check("full order empty", 32'(rdy_def), 32'd0);

    // 7-bit instance: reset mid data bit, line held low across release.
    set_line(2, 1'b0);
    wait_cycles(16);
    set_line(2, 1'b0);
    wait_cycles(16);
    set_line(2, 1'b0);
    wait_cycles(5);
    n_rst_d7 = 1'b0;
    wait_cycles(1);
    check_all(2, "d7 reset", 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    n_rst_d7 = 1'b1;
    wait_cycles(20);
    set_line(2, 1'b1);
    wait_cycles(40);
    check("d7 no false frame", 32'(cnt_d7), 32'd0);
    send_idle(2, 8'h3C, 1'b0, 1'b1);
    check_all(2, "d7 3c", 1'b1, 8'h3C, 1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
